// File: rtl/bp_sat_table.sv
// bp_sat_table: direct-mapped table of saturating branch counters.
// Lookups return the counter one cycle later, and a same-index update
// in that cycle is bypassed through. The table self-initialises after
// reset at one entry per cycle.
// Optional macro BP_GSHARE_EN: XOR a global history register into
// both the lookup and the update index.
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   pred_req/pc/rdy : lookup request, lookup PC, lookups accepted
//   pred_vld/taken  : lookup result valid, predicted direction
//   pred_ctr        : raw counter of the looked-up entry
//   upd_vld/pc      : resolved branch present, its PC
//   upd_taken       : resolved branch outcome
module bp_sat_table #(
  parameter int PC_W     = 32,
  parameter int INDEX_W  = 6,
  parameter int CTR_W    = 2,
  parameter int INIT_CTR = (1 << (CTR_W - 1)) - 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pred_req,
  input  logic [PC_W-1:0]  pred_pc,
  output logic             pred_rdy,
  output logic             pred_vld,
  output logic             pred_taken,
  output logic [CTR_W-1:0] pred_ctr,
  input  logic             upd_vld,
  input  logic [PC_W-1:0]  upd_pc,
  input  logic             upd_taken
);

  localparam int DEPTH = 1 << INDEX_W;

  localparam logic [0:0] S_INIT  = 1'b0;
  localparam logic [0:0] S_READY = 1'b1;

  localparam logic [CTR_W-1:0] CTR_MAX  = '1;
  localparam logic [CTR_W-1:0] CTR_ZERO = '0;
  localparam logic [CTR_W-1:0] CTR_ONE  = CTR_W'(1);
  localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'(INIT_CTR);

  logic [0:0]         state;
  logic [INDEX_W-1:0] init_addr;
  logic [CTR_W-1:0]   table_q [DEPTH];

  logic               ready;
  logic               pred_fire;
  logic               upd_fire;
  logic [INDEX_W-1:0] pred_idx;
  logic [INDEX_W-1:0] upd_idx;
  logic [CTR_W-1:0]   upd_old;
  logic [CTR_W-1:0]   upd_new;
  logic [CTR_W-1:0]   pred_val;

  logic               wr_en;
  logic [INDEX_W-1:0] wr_addr;
  logic [CTR_W-1:0]   wr_data;

  // PC bits outside the index field never matter.
  logic unused_pc;
  assign unused_pc = ^{pred_pc, upd_pc};

  assign ready     = (state == S_READY);
  assign pred_rdy  = ready & ~reset;
  assign pred_fire = pred_req & pred_rdy;
  assign upd_fire  = upd_vld & ready & ~reset;

`ifdef BP_GSHARE_EN
  logic [INDEX_W-1:0] ghr;

  // Both indices use the pre-shift history.
  always_ff @(posedge clk) begin
    if (reset) begin
      ghr <= '0;
    end else if (upd_fire) begin
      ghr <= {ghr[INDEX_W-2:0], upd_taken};
    end
  end

  assign pred_idx = pred_pc[INDEX_W+1:2] ^ ghr;
  assign upd_idx  = upd_pc[INDEX_W+1:2] ^ ghr;
`else
  assign pred_idx = pred_pc[INDEX_W+1:2];
  assign upd_idx  = upd_pc[INDEX_W+1:2];
`endif

  assign upd_old = table_q[upd_idx];

  always_comb begin
    upd_new = upd_old;
    if (upd_taken) begin
      if (upd_old != CTR_MAX) begin
        upd_new = upd_old + CTR_ONE;
      end
    end else if (upd_old != CTR_ZERO) begin
      upd_new = upd_old - CTR_ONE;
    end
  end

  // Write-through: a same-index update is visible to the lookup.
  assign pred_val = (upd_fire && (upd_idx == pred_idx))
                  ? upd_new : table_q[pred_idx];

  always_comb begin
    wr_en   = 1'b0;
    wr_addr = upd_idx;
    wr_data = upd_new;
    if (!reset) begin
      unique case (1'b1)
        (state == S_INIT): begin
          wr_en   = 1'b1;
          wr_addr = init_addr;
          wr_data = CTR_INIT;
        end
        upd_fire: begin
          wr_en = 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      table_q[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_INIT;
      init_addr <= '0;
    end else if (state == S_INIT) begin
      init_addr <= init_addr + 1'b1;
      if (&init_addr) begin
        state <= S_READY;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pred_vld   <= 1'b0;
      pred_taken <= 1'b0;
      pred_ctr   <= '0;
    end else begin
      pred_vld <= pred_fire;
      if (pred_fire) begin
        pred_ctr   <= pred_val;
        pred_taken <= pred_val[CTR_W-1];
      end
    end
  end

endmodule

// File: doc/bp_sat_table.md
BP_SAT_TABLE -- requirements
Module: bp_sat_table

Interface
REQ-001 The block SHALL have parameter PC_W, default 32, meaning the branch PC width in bits.
REQ-002 The block SHALL have parameter INDEX_W, default 6, meaning the table depth is 2^INDEX_W counters; legal range 2..12.
REQ-003 The block SHALL have parameter CTR_W, default 2, meaning the counter width in bits; legal range 2..4.
REQ-004 The block SHALL have parameter INIT_CTR, default 2^(CTR_W-1)-1, meaning the counter value after initialisation (weakly not-taken).
REQ-005 The block SHALL have port clk, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-006 The block SHALL have port reset, input, 1 bit, a synchronous active-high reset.
REQ-007 The block SHALL have port pred_req, input, 1 bit, meaning a prediction lookup is requested this cycle.
REQ-008 The block SHALL have port pred_pc, input, PC_W bits, meaning the lookup PC.
REQ-009 The block SHALL have port pred_rdy, output, 1 bit, meaning lookups are accepted (init complete).
REQ-010 The block SHALL have port pred_vld, output, 1 bit, meaning pred_taken and pred_ctr are valid.
REQ-011 The block SHALL have port pred_taken, output, 1 bit, meaning the predicted direction (counter MSB).
REQ-012 The block SHALL have port pred_ctr, output, CTR_W bits, meaning the raw counter state.
REQ-013 The block SHALL have port upd_vld, input, 1 bit, meaning a resolved branch outcome is presented.
REQ-014 The block SHALL have port upd_pc, input, PC_W bits, meaning the PC of the resolved branch.
REQ-015 The block SHALL have port upd_taken, input, 1 bit, meaning the actual branch outcome.

Function
REQ-016 Table index SHALL be pc[INDEX_W+1:2]; PC bits [1:0] are ignored.
REQ-017 The FSM SHALL have states INIT and READY; reset enters INIT, and INIT moves to READY after exactly 2^INDEX_W cycles.
REQ-018 In INIT the FSM SHALL write INIT_CTR to one entry per cycle at ascending addresses 0..2^INDEX_W-1; pred_rdy=0 and upd_vld/pred_req are ignored.
REQ-019 In READY pred_rdy SHALL be 1.
REQ-020 A lookup accepted (pred_req & pred_rdy) in cycle N SHALL drive pred_vld=1 with its result in cycle N+1 (one-cycle latency); otherwise pred_vld=0 in N+1.
REQ-021 An update in READY SHALL increment the indexed counter if upd_taken=1, or decrement it if upd_taken=0.
REQ-022 Counters SHALL saturate at 2^CTR_W-1 and at 0, with no wrap-around.
REQ-023 An update and a lookup to the same index in the same cycle SHALL return the post-update counter value (write-through bypass).
REQ-024 An update and a lookup to different indices in the same cycle SHALL both complete with no stall.
REQ-025 The block SHALL accept one update and one lookup every cycle; there is no backpressure in READY.

Reset
REQ-026 While reset=1: the FSM SHALL enter INIT with init address 0, pred_vld=0, pred_taken=0, pred_ctr=0, and pred_rdy=0.
REQ-027 A reset asserted mid-INIT or mid-READY SHALL restart initialisation from address 0, and a pending lookup result SHALL be dropped.

Configuration
REQ-028 Macro BP_GSHARE_EN SHALL, when defined, add an INDEX_W-bit global history register reset to 0 and updated each update cycle as {ghr[INDEX_W-2:0], upd_taken}.
REQ-029 With BP_GSHARE_EN defined, the lookup index SHALL be pc[INDEX_W+1:2] XOR ghr, and the update index SHALL be upd_pc[INDEX_W+1:2] XOR the ghr value before the shift.
REQ-030 With BP_GSHARE_EN defined, same-cycle update and lookup SHALL use the pre-shift ghr for both.
REQ-031 Without BP_GSHARE_EN, no history register SHALL exist and indexing SHALL follow REQ-016 only.

Verification (INDEX_W=4, CTR_W=2, BP_GSHARE_EN undefined unless stated)
REQ-032 Scenario init: reset for 1 cycle, then release -> pred_rdy=0 for 16 cycles then 1; a lookup of any PC gives pred_ctr=1, pred_taken=0.
REQ-033 Scenario saturation: 4 updates taken to pc=0x10 -> pred_ctr=3; then 5 not-taken updates -> pred_ctr=0 with no wrap.
REQ-034 Scenario bypass: pred_ctr=1 at pc=0x20, same-cycle update taken plus lookup of 0x20 -> next cycle pred_vld=1, pred_ctr=2, pred_taken=1.
REQ-035 Scenario aliasing: update taken to pc=0x04, then lookup pc=0x44 -> pred_ctr=2 (shared index 1); lookup pc=0x08 -> pred_ctr=1.
REQ-036 Scenario mid-op reset: reset at INIT address 7 and again in READY -> full 16-cycle reinit; all counters read 1; pred_vld=0 during reset.
REQ-037 Scenario gshare (BP_GSHARE_EN): updates taken, taken at pc=0 -> ghr=0b0011; lookup pc=0 reads index 3.
